multi_digit_sub: RTL and testbench

- Parametrised sequential subtractor: computes `diff = a - b - borrow_in` over WIDTH bits, DIGIT bits per clock, rippling the borrow between digits in a registered chain.
- Successor to the single-bit half subtractor: same borrow/difference semantics, generalised in width, with a start/busy/done handshake and a configurable area/latency trade-off.
- Sits in the arithmetic datapath as the reusable N-bit subtract primitive.

---
 rtl/multi_digit_sub.sv | 111 +++++++++++
 tb/tb_multi_digit_sub.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multi_digit_sub.sv
// Sequential subtractor: diff = a - b - borrow_in over WIDTH bits, DIGIT bits per clock.
// Define SUB_FLAGS_EN to add the registered zero and ovf result flags.
module multi_digit_sub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SUB_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
            $error("multi_digit_sub: WIDTH must be a non-zero multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q, b_q, work, next_work;
    logic             borrow;
    logic [IW-1:0]    idx;
    logic [DIGIT-1:0] a_dig, b_dig;
    logic [DIGIT:0]   sub;
    logic             last;

    // Top bit of the (DIGIT+1)-bit difference is the borrow out of this digit.
    always_comb begin
        a_dig     = a_q[idx*DIGIT +: DIGIT];
        b_dig     = b_q[idx*DIGIT +: DIGIT];
        sub       = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, borrow};
        next_work = work;
        next_work[idx*DIGIT +: DIGIT] = sub[DIGIT-1:0];
        last      = (idx == IW'(N - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            work       <= '0;
            borrow     <= 1'b0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
`ifdef SUB_FLAGS_EN
            zero       <= 1'b0;
            ovf        <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q    <= a;
                        b_q    <= b;
                        borrow <= borrow_in;
                        work   <= '0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    work   <= next_work;
                    borrow <= sub[DIGIT];
                    idx    <= idx + 1'b1;
                    if (last) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        diff       <= next_work;
                        borrow_out <= sub[DIGIT];
`ifdef SUB_FLAGS_EN
                        zero       <= (next_work == '0);
                        ovf        <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                      (next_work[WIDTH-1] != a_q[WIDTH-1]);
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_digit_sub.sv
// Bench for multi_digit_sub: a 16/4 and a 16/16 instance against a transaction-level model.
// Zero/ovf are checked when SUB_FLAGS_EN is defined.
module tb_multi_digit_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        borrow_in = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic        busy0, done0, bo0, busy1, done1, bo1;
    logic [15:0] diff0, diff1;
`ifdef SUB_FLAGS_EN
    logic        zero0, ovf0, zero1, ovf1;
`endif

    always #5 clk = ~clk;

    multi_digit_sub #(.WIDTH(16), .DIGIT(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
        .busy(busy0), .done(done0), .diff(diff0), .borrow_out(bo0)
`ifdef SUB_FLAGS_EN
        , .zero(zero0), .ovf(ovf0)
`endif
    );

    multi_digit_sub #(.WIDTH(16), .DIGIT(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
        .busy(busy1), .done(done1), .diff(diff1), .borrow_out(bo1)
`ifdef SUB_FLAGS_EN
        , .zero(zero1), .ovf(ovf1)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] sub16(input logic [15:0] x, input logic [15:0] y, input bit bi);
        return x - y - 16'(bi);
    endfunction

    // Transaction-level model: an accepted op is busy for N cycles, then the result appears.
    int unsigned m_rem[2];
    bit          m_busy[2], m_done[2], m_bo[2], m_zero[2], m_ovf[2], m_bin[2];
    logic [15:0] m_diff[2], m_a[2], m_b[2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_rem[k] <= 0; m_busy[k] <= 0; m_done[k] <= 0; m_bo[k] <= 0;
                m_zero[k] <= 0; m_ovf[k] <= 0; m_diff[k] <= '0;
            end else if (!m_busy[k] && start) begin
                m_busy[k] <= 1; m_done[k] <= 0;
                m_rem[k]  <= (k == 0) ? 4 : 1;
                m_a[k] <= a; m_b[k] <= b; m_bin[k] <= borrow_in;
            end else begin
                m_done[k] <= 0;
                if (m_busy[k]) begin
                    m_rem[k] <= m_rem[k] - 1;
                    if (m_rem[k] == 1) begin
                        m_busy[k] <= 0;
                        m_done[k] <= 1;
                        m_diff[k] <= sub16(m_a[k], m_b[k], m_bin[k]);
                        m_bo[k]   <= (32'(m_a[k]) < 32'(m_b[k]) + 32'(m_bin[k]));
                        m_zero[k] <= (sub16(m_a[k], m_b[k], m_bin[k]) == 16'h0);
                        m_ovf[k]  <= (m_a[k][15] != m_b[k][15]) &&
                                     (sub16(m_a[k], m_b[k], m_bin[k]) >= 16'h8000) != m_a[k][15];
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("cmp_busy0", busy0, m_busy[0]);
        chk("cmp_done0", done0, m_done[0]);
        chk("cmp_diff0", diff0, m_diff[0]);
        chk("cmp_bo0",   bo0,   m_bo[0]);
        chk("cmp_busy1", busy1, m_busy[1]);
        chk("cmp_done1", done1, m_done[1]);
        chk("cmp_diff1", diff1, m_diff[1]);
        chk("cmp_bo1",   bo1,   m_bo[1]);
`ifdef SUB_FLAGS_EN
        chk("cmp_zero0", zero0, m_zero[0]);
        chk("cmp_ovf0",  ovf0,  m_ovf[0]);
        chk("cmp_zero1", zero1, m_zero[1]);
        chk("cmp_ovf1",  ovf1,  m_ovf[1]);
`endif
    end

    // Start one op on the N=4 instance and pin its timing and result to literals.
    task automatic op(input string name, input logic [15:0] xa, input logic [15:0] xb,
                      input bit xbin, input logic [15:0] ediff, input bit ebo,
                      input bit ezero, input bit eovf);
        int cyc = 0;
        int bc = 0;
        bit got = 0;
        a = xa; b = xb; borrow_in = xbin; start = 1'b1;
        while (!got && cyc < 20) begin
            @(negedge clk);
            start = 1'b0;
            a = 16'($urandom); b = 16'($urandom); borrow_in = 1'($urandom);
            cyc++;
            if (busy0) bc++;
            if (done0) got = 1;
        end
        chk({name, "_latency"}, cyc, 5);
        chk({name, "_busy_cycles"}, bc, 4);
        chk({name, "_diff"}, diff0, ediff);
        chk({name, "_borrow"}, bo0, ebo);
`ifdef SUB_FLAGS_EN
        chk({name, "_zero"}, zero0, ezero);
        chk({name, "_ovf"}, ovf0, eovf);
`else
        if (ezero && eovf) chk({name, "_flags_unused"}, 0, 0);
`endif
    endtask

    task automatic wait_done0(input int max, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done0 && cyc < max);
    endtask

    initial begin
        int cyc;
        int dcount;

        repeat (2) @(negedge clk);
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_diff", diff0, 0);
        chk("rst_borrow", bo0, 0);
        rst_n = 1'b1;
        @(negedge clk);

        op("basic",      16'h1234, 16'h0234, 0, 16'h1000, 0, 0, 0);
        op("underflow",  16'h0000, 16'h0001, 0, 16'hFFFF, 1, 0, 0);
        op("bin_under",  16'h0005, 16'h0005, 1, 16'hFFFF, 1, 0, 0);
        op("equal_zero", 16'h0005, 16'h0005, 0, 16'h0000, 0, 1, 0);
        op("signed_ovf", 16'h8000, 16'h0001, 0, 16'h7FFF, 0, 0, 1);
        repeat (3) @(negedge clk);

        // Start pulse during RUN cycle 2 must be ignored.
        a = 16'h0010; b = 16'h0001; borrow_in = 0; start = 1'b1;
        dcount = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            start = (i == 1);
            if (i == 1) a = 16'hFFFF;
            if (done0) dcount++;
        end
        chk("busy_start_dones", dcount, 1);
        chk("busy_start_diff", diff0, 16'h000F);

        // Back-to-back: start held in the DONE cycle.
        a = 16'h0003; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done0(20, cyc);
        chk("b2b_first_done", done0, 1);
        a = 16'h0100; b = 16'h0001; borrow_in = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", busy0, 1);
        wait_done0(20, cyc);
        chk("b2b_spacing", cyc + 1, 5);
        chk("b2b_diff", diff0, 16'h00FF);
        repeat (2) @(negedge clk);

        // Reset in RUN cycle 2.
        a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy0, 0);
        chk("midrst_done", done0, 0);
        chk("midrst_diff", diff0, 0);
        rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done0) dcount++;
        end
        chk("midrst_no_done", dcount, 0);

        // DIGIT=WIDTH instance: done in the cycle after acceptance.
        a = 16'd3; b = 16'd5; borrow_in = 0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("d16_busy", busy1, 1);
        chk("d16_early_done", done1, 0);
        @(negedge clk);
        chk("d16_done", done1, 1);
        chk("d16_diff", diff1, 16'hFFFE);
        chk("d16_borrow", bo1, 1);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            start     = ($urandom_range(0, 2) == 0);
            a         = 16'($urandom);
            b         = 16'($urandom);
            borrow_in = 1'($urandom);
            rst_n     = ($urandom_range(0, 79) != 0);
        end
        rst_n = 1'b1;
        start = 1'b0;
        repeat (8) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
